// File: rtl/sd_controller_pkg.sv
// Shared definitions for the SD controller: transfer sequencer state encoding and the
// bit positions of the control/status registers (also used by the AXI-lite register file).
package sd_controller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        FINISH,
        ERROR
    } seq_state_t;

    // reg_status bit positions
    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_ERR_BIT  = 1;
    localparam int unsigned STATUS_IRQ_BIT  = 2;
    localparam int unsigned STATUS_DONE_BIT = 3;

    // reg_ctrl bit positions
    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_IRQEN_BIT = 1;

endpackage

// File: rtl/sd_transfer_sequencer.sv
// Multi-sector SD-to-memory read sequencer.
// For each sector it issues one read command to the SD data core and one write descriptor
// to the DMA writer, waits for both completions, then advances to the next sector.
// Ports:
//   aclk / aresetn                   clock, asynchronous active-low reset
//   reg_ctrl .. reg_reset            control registers from the register file
//   reg_status, reg_progress, irq    status back to the register file / system
//   sd_cmd_*  / sd_rsp_*             sector read request (valid/ready) and completion pulse
//   dma_req_* / dma_done_*           write descriptor (valid/ready) and completion pulse
module sd_transfer_sequencer
    import sd_controller_pkg::*;
#(
    parameter int unsigned SECTOR_LOG2 = 9
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] reg_ctrl,
    input  logic [31:0] reg_dstaddr,
    input  logic [31:0] reg_startsector,
    input  logic [22:0] reg_sectornum,
    input  logic        interrupt_clear,
    input  logic        reg_reset,
    output logic [31:0] reg_status,
    output logic [31:0] reg_progress,
    output logic        irq,
    output logic        sd_cmd_valid,
    input  logic        sd_cmd_ready,
    output logic [31:0] sd_cmd_sector,
    input  logic        sd_rsp_valid,
    input  logic        sd_rsp_err,
    output logic        dma_req_valid,
    input  logic        dma_req_ready,
    output logic [31:0] dma_req_addr,
    input  logic        dma_done_valid,
    input  logic        dma_done_err
);

    seq_state_t  state_q, state_d;
    logic [22:0] idx_q, idx_d;
    logic [22:0] total_q, total_d;
    logic [22:0] progress_q, progress_d;
    logic [31:0] base_addr_q, base_addr_d;
    logic [31:0] base_sector_q, base_sector_d;
    logic        int_en_q, int_en_d;
    logic        cmd_sent_q, cmd_sent_d;
    logic        dma_sent_q, dma_sent_d;
    logic        sd_ok_q, sd_ok_d;
    logic        dma_ok_q, dma_ok_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        irq_pend_q, irq_pend_d;
    logic        irq_q, irq_d;
    logic        sd_cmd_valid_q, sd_cmd_valid_d;
    logic [31:0] sd_cmd_sector_q, sd_cmd_sector_d;
    logic        dma_req_valid_q, dma_req_valid_d;
    logic [31:0] dma_req_addr_q, dma_req_addr_d;

    logic        start;
    logic        irq_set;
    logic        xfer_err;
    logic [22:0] idx_inc;
    logic        unused_ctrl;

    assign start       = reg_ctrl[CTRL_START_BIT];
    assign unused_ctrl = ^reg_ctrl[31:2];
    assign idx_inc     = idx_q + 23'd1;
    assign xfer_err    = (sd_rsp_valid & sd_rsp_err) | (dma_done_valid & dma_done_err);

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        total_d         = total_q;
        progress_d      = progress_q;
        base_addr_d     = base_addr_q;
        base_sector_d   = base_sector_q;
        int_en_d        = int_en_q;
        cmd_sent_d      = cmd_sent_q;
        dma_sent_d      = dma_sent_q;
        sd_ok_d         = sd_ok_q;
        dma_ok_d        = dma_ok_q;
        done_d          = done_q;
        error_d         = error_q;
        irq_pend_d      = irq_pend_q;
        irq_set         = 1'b0;

        if (reg_reset) begin
            // Soft reset beats start and any pending handshake; latched config is kept.
            state_d    = IDLE;
            idx_d      = '0;
            progress_d = '0;
            cmd_sent_d = 1'b0;
            dma_sent_d = 1'b0;
            sd_ok_d    = 1'b0;
            dma_ok_d   = 1'b0;
            done_d     = 1'b0;
            error_d    = 1'b0;
            irq_pend_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        base_addr_d   = reg_dstaddr;
                        base_sector_d = reg_startsector;
                        total_d       = reg_sectornum;
                        int_en_d      = reg_ctrl[CTRL_IRQEN_BIT];
                        done_d        = 1'b0;
                        error_d       = 1'b0;
                        progress_d    = '0;
                        idx_d         = '0;
                        cmd_sent_d    = 1'b0;
                        dma_sent_d    = 1'b0;
                        sd_ok_d       = 1'b0;
                        dma_ok_d      = 1'b0;
                        state_d       = (reg_sectornum != '0) ? XFER : FINISH;
                    end
                end
                XFER: begin
                    cmd_sent_d = cmd_sent_q | (sd_cmd_valid_q & sd_cmd_ready);
                    dma_sent_d = dma_sent_q | (dma_req_valid_q & dma_req_ready);
                    sd_ok_d    = sd_ok_q | sd_rsp_valid;
                    dma_ok_d   = dma_ok_q | dma_done_valid;
                    if (xfer_err) begin
                        // Failing sector is not counted.
                        state_d = ERROR;
                    end else if (sd_ok_d && dma_ok_d) begin
                        idx_d      = idx_inc;
                        progress_d = idx_inc;
                        if (idx_inc == total_q) begin
                            state_d = FINISH;
                        end else begin
                            cmd_sent_d = 1'b0;
                            dma_sent_d = 1'b0;
                            sd_ok_d    = 1'b0;
                            dma_ok_d   = 1'b0;
                        end
                    end
                end
                FINISH: begin
                    done_d  = 1'b1;
                    irq_set = 1'b1;
                    state_d = IDLE;
                end
                ERROR: begin
                    error_d = 1'b1;
                    irq_set = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            // A set in the same cycle as a clear wins.
            if (irq_set) begin
                irq_pend_d = 1'b1;
            end else if (interrupt_clear) begin
                irq_pend_d = 1'b0;
            end
        end

        irq_d = irq_pend_d & int_en_d;

        // Requests only rise while already in XFER, giving the start-to-valid latency of two
        // cycles; leaving XFER (finish, error, soft reset) drops them.
        sd_cmd_valid_d  = (state_q == XFER) && (state_d == XFER) && !cmd_sent_d;
        dma_req_valid_d = (state_q == XFER) && (state_d == XFER) && !dma_sent_d;
        sd_cmd_sector_d = base_sector_q + 32'(idx_d);
        dma_req_addr_d  = base_addr_q + (32'(idx_d) << SECTOR_LOG2);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            total_q         <= '0;
            progress_q      <= '0;
            base_addr_q     <= '0;
            base_sector_q   <= '0;
            int_en_q        <= 1'b0;
            cmd_sent_q      <= 1'b0;
            dma_sent_q      <= 1'b0;
            sd_ok_q         <= 1'b0;
            dma_ok_q        <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            irq_pend_q      <= 1'b0;
            irq_q           <= 1'b0;
            sd_cmd_valid_q  <= 1'b0;
            sd_cmd_sector_q <= '0;
            dma_req_valid_q <= 1'b0;
            dma_req_addr_q  <= '0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            total_q         <= total_d;
            progress_q      <= progress_d;
            base_addr_q     <= base_addr_d;
            base_sector_q   <= base_sector_d;
            int_en_q        <= int_en_d;
            cmd_sent_q      <= cmd_sent_d;
            dma_sent_q      <= dma_sent_d;
            sd_ok_q         <= sd_ok_d;
            dma_ok_q        <= dma_ok_d;
            done_q          <= done_d;
            error_q         <= error_d;
            irq_pend_q      <= irq_pend_d;
            irq_q           <= irq_d;
            sd_cmd_valid_q  <= sd_cmd_valid_d;
            sd_cmd_sector_q <= sd_cmd_sector_d;
            dma_req_valid_q <= dma_req_valid_d;
            dma_req_addr_q  <= dma_req_addr_d;
        end
    end

    always_comb begin
        reg_status                  = '0;
        reg_status[STATUS_BUSY_BIT] = (state_q != IDLE);
        reg_status[STATUS_ERR_BIT]  = error_q;
        reg_status[STATUS_IRQ_BIT]  = irq_pend_q;
        reg_status[STATUS_DONE_BIT] = done_q;
    end

    assign reg_progress  = {9'b0, progress_q};
    assign irq           = irq_q;
    assign sd_cmd_valid  = sd_cmd_valid_q;
    assign sd_cmd_sector = sd_cmd_sector_q;
    assign dma_req_valid = dma_req_valid_q;
    assign dma_req_addr  = dma_req_addr_q;

endmodule

// File: tb/tb_sd_transfer_sequencer.sv
// Self-checking bench for sd_transfer_sequencer: table of whole transfers plus hand-written
// sequences for error, soft/hard reset, busy start and interrupt set/clear collisions.
module tb_sd_transfer_sequencer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic [31:0] reg_ctrl = '0, reg_dstaddr = '0, reg_startsector = '0;
    logic [22:0] reg_sectornum = '0;
    logic        interrupt_clear = 1'b0, reg_reset = 1'b0;
    logic [31:0] reg_status, reg_progress;
    logic        irq;
    logic        sd_cmd_valid, sd_cmd_ready;
    logic [31:0] sd_cmd_sector;
    logic        sd_rsp_valid, sd_rsp_err;
    logic        dma_req_valid, dma_req_ready;
    logic [31:0] dma_req_addr;
    logic        dma_done_valid, dma_done_err;

    sd_transfer_sequencer #(.SECTOR_LOG2(9)) dut (
        .aclk(aclk), .aresetn(aresetn), .reg_ctrl(reg_ctrl), .reg_dstaddr(reg_dstaddr),
        .reg_startsector(reg_startsector), .reg_sectornum(reg_sectornum),
        .interrupt_clear(interrupt_clear), .reg_reset(reg_reset), .reg_status(reg_status),
        .reg_progress(reg_progress), .irq(irq), .sd_cmd_valid(sd_cmd_valid),
        .sd_cmd_ready(sd_cmd_ready), .sd_cmd_sector(sd_cmd_sector),
        .sd_rsp_valid(sd_rsp_valid), .sd_rsp_err(sd_rsp_err), .dma_req_valid(dma_req_valid),
        .dma_req_ready(dma_req_ready), .dma_req_addr(dma_req_addr),
        .dma_done_valid(dma_done_valid), .dma_done_err(dma_done_err)
    );

    initial forever #5 aclk = ~aclk;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_cmd_q[$];
    logic [31:0] exp_dma_q[$];
    bit relax = 1'b0;  // withdrawal of a pending valid is legal (error / resets)

    // Responder knobs and state
    int sd_lat = 3, dma_lat = 3, sd_rdy = 0, dma_rdy = 0, sd_err_at = -1, dma_err_at = -1;
    int sd_wait = 0, dma_wait = 0, sd_cd = -1, dma_cd = -1, sd_cnt = 0, dma_cnt = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(negedge aclk);
    endtask

    task automatic reset_resp();
        sd_wait = 0; dma_wait = 0; sd_cd = -1; dma_cd = -1; sd_cnt = 0; dma_cnt = 0;
        sd_err_at = -1; dma_err_at = -1;
    endtask

    task automatic push_exp(logic [31:0] dst, logic [31:0] ssec, int n);
        logic [31:0] s, a;
        for (int i = 0; i < n; i++) begin
            s = ssec + 32'(i);
            a = dst + (32'(i) << 9);
            exp_cmd_q.push_back(s);
            exp_dma_q.push_back(a);
        end
    endtask

    // Called at a negedge; returns one cycle later with start deasserted.
    task automatic start_xfer(logic [31:0] dst, logic [31:0] ssec, logic [22:0] num,
                              logic ien, bit push);
        if (push) push_exp(dst, ssec, int'(num));
        reg_dstaddr     = dst;
        reg_startsector = ssec;
        reg_sectornum   = num;
        reg_ctrl        = {30'b0, ien, 1'b1};
        @(negedge aclk);
        reg_ctrl = '0;
    endtask

    task automatic wait_idle(string name);
        int cyc = 0;
        while (reg_status[0] && cyc < 2000) begin
            @(negedge aclk);
            cyc++;
        end
        check({name, " idle timeout"}, 32'(cyc < 2000), 32'd1);
    endtask

    // SD core model: accepts after sd_rdy cycles of valid, responds sd_lat cycles later.
    initial begin
        sd_cmd_ready = 0; sd_rsp_valid = 0; sd_rsp_err = 0;
        forever begin
            @(negedge aclk);
            sd_cmd_ready = 0; sd_rsp_valid = 0; sd_rsp_err = 0;
            if (sd_cd == 0) begin
                sd_rsp_valid = 1; sd_rsp_err = (sd_cnt == sd_err_at); sd_cnt++; sd_cd = -1;
            end else if (sd_cd > 0) sd_cd--;
            if (sd_cmd_valid && aresetn) begin
                if (sd_wait >= sd_rdy) begin sd_cmd_ready = 1; sd_wait = 0; sd_cd = sd_lat; end
                else sd_wait++;
            end else sd_wait = 0;
        end
    end

    // DMA writer model
    initial begin
        dma_req_ready = 0; dma_done_valid = 0; dma_done_err = 0;
        forever begin
            @(negedge aclk);
            dma_req_ready = 0; dma_done_valid = 0; dma_done_err = 0;
            if (dma_cd == 0) begin
                dma_done_valid = 1; dma_done_err = (dma_cnt == dma_err_at); dma_cnt++;
                dma_cd = -1;
            end else if (dma_cd > 0) dma_cd--;
            if (dma_req_valid && aresetn) begin
                if (dma_wait >= dma_rdy) begin
                    dma_req_ready = 1; dma_wait = 0; dma_cd = dma_lat;
                end else dma_wait++;
            end else dma_wait = 0;
        end
    end

    // Monitor: scoreboard on handshakes, request stability, progress stepping.
    initial begin
        logic        p_sv = 0, p_dv = 0;
        logic [31:0] p_ss = '0, p_da = '0, p_pg = '0;
        logic [31:0] e;
        forever begin
            @(posedge aclk);
            #1;
            if (aresetn) begin
                if (p_sv && sd_cmd_ready) begin
                    if (exp_cmd_q.size() == 0) check("unexpected sd cmd", p_ss, 32'hFFFF_FFFF);
                    else begin e = exp_cmd_q.pop_front(); check("sd cmd sector", p_ss, e); end
                end else if (p_sv && !relax) begin
                    check("sd valid held", 32'(sd_cmd_valid), 32'd1);
                    check("sd sector held", sd_cmd_sector, p_ss);
                end
                if (p_dv && dma_req_ready) begin
                    if (exp_dma_q.size() == 0) check("unexpected dma req", p_da, 32'hFFFF_FFFF);
                    else begin e = exp_dma_q.pop_front(); check("dma req addr", p_da, e); end
                end else if (p_dv && !relax) begin
                    check("dma valid held", 32'(dma_req_valid), 32'd1);
                    check("dma addr held", dma_req_addr, p_da);
                end
                if (reg_progress != p_pg && reg_progress != 0)
                    check("progress step", reg_progress, p_pg + 32'd1);
            end
            p_sv = sd_cmd_valid && aresetn; p_ss = sd_cmd_sector;
            p_dv = dma_req_valid && aresetn; p_da = dma_req_addr;
            p_pg = reg_progress;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] dst;
        logic [31:0] ssec;
        logic [22:0] num;
        logic        ien;
        int          sl, dl, sr, dr;
        logic [31:0] exp_status;
        logic [31:0] exp_prog;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit any;
        vecs[0] = '{32'h8000_0000, 32'd100, 23'd4, 1'b1, 3, 3, 0, 0, 32'hC, 32'd4, 1'b1};
        vecs[1] = '{32'h0000_1000, 32'd7, 23'd2, 1'b0, 6, 1, 0, 0, 32'hC, 32'd2, 1'b0};
        vecs[2] = '{32'h0010_0000, 32'd20, 23'd2, 1'b1, 2, 2, 0, 0, 32'hC, 32'd2, 1'b1};
        vecs[3] = '{32'h0020_0000, 32'd30, 23'd2, 1'b0, 1, 1, 10, 2, 32'hC, 32'd2, 1'b0};
        vecs[4] = '{32'hFFFF_FE00, 32'hFFFF_FFFF, 23'd2, 1'b1, 3, 3, 0, 0, 32'hC, 32'd2, 1'b1};
        vecs[5] = '{32'h0000_4000, 32'd9, 23'd0, 1'b0, 3, 3, 0, 0, 32'hC, 32'd0, 1'b0};

        // Power-on reset
        #1 aresetn = 1'b0;
        #12;
        check("reset status", reg_status, 32'h0);
        check("reset progress", reg_progress, 32'h0);
        check("reset valids", {30'b0, sd_cmd_valid, dma_req_valid}, 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        tick(2);

        for (int v = 0; v < 6; v++) begin
            reset_resp();
            sd_lat = vecs[v].sl; dma_lat = vecs[v].dl; sd_rdy = vecs[v].sr; dma_rdy = vecs[v].dr;
            start_xfer(vecs[v].dst, vecs[v].ssec, vecs[v].num, vecs[v].ien, 1'b1);
            wait_idle($sformatf("v%0d", v));
            check($sformatf("v%0d status", v), reg_status, vecs[v].exp_status);
            check($sformatf("v%0d progress", v), reg_progress, vecs[v].exp_prog);
            check($sformatf("v%0d irq", v), 32'(irq), 32'(vecs[v].exp_irq));
            tick(8);
            check($sformatf("v%0d sd queue drained", v), exp_cmd_q.size(), 0);
            check($sformatf("v%0d dma queue drained", v), exp_dma_q.size(), 0);
            interrupt_clear = 1'b1;
            @(negedge aclk);
            interrupt_clear = 1'b0;
            check($sformatf("v%0d status after clear", v), reg_status, vecs[v].exp_status & ~32'h4);
            check($sformatf("v%0d irq after clear", v), 32'(irq), 32'h0);
        end

        // Interrupt set and clear in the same cycle: set wins.
        reset_resp(); sd_lat = 3; dma_lat = 3; sd_rdy = 0; dma_rdy = 0;
        start_xfer(32'h0, 32'h0, 23'd0, 1'b1, 1'b1);
        interrupt_clear = 1'b1;
        @(negedge aclk);
        interrupt_clear = 1'b0;
        check("set/clear status", reg_status, 32'hC);
        check("set/clear irq", 32'(irq), 32'h1);
        interrupt_clear = 1'b1; tick(); interrupt_clear = 1'b0;
        check("set/clear irq cleared", 32'(irq), 32'h0);

        // Start while busy is ignored (latched values and int_en unchanged).
        reset_resp();
        start_xfer(32'h4000_0000, 32'd500, 23'd4, 1'b0, 1'b1);
        tick(4);
        start_xfer(32'hDEAD_0000, 32'd999, 23'd2, 1'b1, 1'b0);
        wait_idle("busy start");
        check("busy start progress", reg_progress, 32'd4);
        check("busy start status", reg_status, 32'hC);
        check("busy start irq", 32'(irq), 32'h0);
        tick(8);
        check("busy start queue", exp_cmd_q.size() + exp_dma_q.size(), 0);
        interrupt_clear = 1'b1; tick(); interrupt_clear = 1'b0;

        // SD error on sector 2 of 6.
        reset_resp(); sd_err_at = 2; relax = 1'b1;
        push_exp(32'h0000_2000, 32'd50, 3);
        start_xfer(32'h0000_2000, 32'd50, 23'd6, 1'b1, 1'b0);
        wait_idle("error");
        check("error status", reg_status, 32'h6);
        check("error progress", reg_progress, 32'd2);
        check("error irq", 32'(irq), 32'h1);
        any = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            any |= sd_cmd_valid | dma_req_valid;
        end
        check("no requests after error", 32'(any), 32'h0);
        check("error queue", exp_cmd_q.size() + exp_dma_q.size(), 0);
        relax = 1'b0;
        interrupt_clear = 1'b1; tick(); interrupt_clear = 1'b0;
        reset_resp();
        start_xfer(32'h0000_3000, 32'd60, 23'd2, 1'b0, 1'b1);
        check("restart clears error", 32'(reg_status[1]), 32'h0);
        wait_idle("restart");
        check("restart status", reg_status, 32'hC);
        interrupt_clear = 1'b1; tick(); interrupt_clear = 1'b0;

        // Soft reset with a DMA descriptor pending.
        tick(4);
        reset_resp(); sd_lat = 1; dma_rdy = 30;
        exp_cmd_q.push_back(32'd70);
        start_xfer(32'h0000_5000, 32'd70, 23'd4, 1'b1, 1'b0);
        tick(6);
        check("dma pending before soft reset", 32'(dma_req_valid), 32'h1);
        relax = 1'b1;
        reg_reset = 1'b1;
        @(negedge aclk);
        reg_reset = 1'b0;
        check("soft reset valids", {30'b0, sd_cmd_valid, dma_req_valid}, 32'h0);
        check("soft reset status", reg_status, 32'h0);
        check("soft reset progress", reg_progress, 32'h0);
        tick(40);
        check("soft reset no irq", 32'(irq), 32'h0);
        check("soft reset stays idle", reg_status, 32'h0);
        check("soft reset queue", exp_cmd_q.size(), 0);
        exp_dma_q.delete();
        relax = 1'b0; dma_rdy = 0;

        // Asynchronous hard reset mid-transfer.
        reset_resp(); sd_lat = 3;
        start_xfer(32'h0000_6000, 32'd80, 23'd4, 1'b1, 1'b1);
        tick(3);
        check("busy before hard reset", 32'(reg_status[0]), 32'h1);
        relax = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        check("hard reset status", reg_status, 32'h0);
        check("hard reset progress", reg_progress, 32'h0);
        check("hard reset irq", 32'(irq), 32'h0);
        check("hard reset valids", {30'b0, sd_cmd_valid, dma_req_valid}, 32'h0);
        check("hard reset sector", sd_cmd_sector, 32'h0);
        check("hard reset addr", dma_req_addr, 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        tick(10);
        check("idle after hard reset", reg_status, 32'h0);
        exp_cmd_q.delete(); exp_dma_q.delete();
        relax = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_transfer_sequencer.md
Name: sd_transfer_sequencer

Overview:
- Sits directly downstream of the AXI-lite register file.
- Consumes the control registers (ctrl, dstaddr, startsector, sectornum, interrupt_clear, reg_reset).
- Sequences a multi-sector SD-to-memory read, one sector at a time: issues a sector read command to the SD data core and a matching 512-byte write descriptor to the DMA writer.
- Produces reg_status, reg_progress and the interrupt line back to the register file and the system.

Parameters:
SECTOR_LOG2, 9, log2 of bytes per sector; destination address stride is 1<<SECTOR_LOG2.

Ports:
aclk  input  1  clock
aresetn  input  1  reset, asynchronous, active-low
reg_ctrl  input  32  bit0 start pulse (one cycle), bit1 interrupt enable
reg_dstaddr  input  32  destination byte address of sector 0
reg_startsector  input  32  first SD sector index
reg_sectornum  input  23  sectors to transfer (bit0 always 0)
interrupt_clear  input  1  one-cycle pulse, clears irq pending
reg_reset  input  1  one-cycle soft reset pulse
reg_status  output  32  bit0 busy, bit1 error, bit2 irq_pending, bit3 done, others 0
reg_progress  output  32  sectors completed, zero-extended from 23 bits
irq  output  1  interrupt, level
sd_cmd_valid  output  1  sector read request valid
sd_cmd_ready  input  1  SD core accepts request
sd_cmd_sector  output  32  sector index of request
sd_rsp_valid  input  1  one-cycle pulse, sector read finished (no backpressure)
sd_rsp_err  input  1  qualifies sd_rsp_valid, CRC/timeout error
dma_req_valid  output  1  write descriptor valid
dma_req_ready  input  1  DMA accepts descriptor
dma_req_addr  output  32  destination address of descriptor
dma_done_valid  input  1  one-cycle pulse, descriptor written to memory
dma_done_err  input  1  qualifies dma_done_valid, bus error

Behaviour:
- Clocking and reset:
  - All state is flopped on posedge aclk.
  - aresetn low asynchronously forces: state IDLE, all outputs 0, all counters and flags 0.
- States: IDLE, XFER, FINISH, ERROR.
- Registers: idx[22:0] (sector index), total[22:0], base_addr, base_sector, int_en, and the four per-sector flags cmd_sent, dma_sent, sd_ok, dma_ok.
- IDLE:
  - On reg_ctrl[0], latch dstaddr, startsector, sectornum and int_en (reg_ctrl[1]).
  - Clear done, error and progress; idx=0.
  - Go to XFER if sectornum!=0, else go to FINISH (zero-length transfer completes without any command).
- Start while busy (XFER/FINISH) is ignored; latched values are unchanged.
- XFER request side:
  - sd_cmd_valid = !cmd_sent, with sd_cmd_sector = base_sector+idx, wrapping modulo 2^32.
  - dma_req_valid = !dma_sent, with dma_req_addr = base_addr+(idx<<SECTOR_LOG2), wrapping modulo 2^32.
  - Both are registered outputs, asserted the cycle after entering XFER or advancing idx.
  - Each is held stable until its ready is seen with valid high, then drops the next cycle and its sent flag sets.
  - The two handshakes are independent; they may complete in either order or in the same cycle.
- XFER completion side:
  - sd_rsp_valid sets sd_ok; dma_done_valid sets dma_ok. They may arrive in either order or in the same cycle.
  - When sd_ok&dma_ok (including flags setting this cycle):
    - idx++ and progress=idx+1.
    - If idx+1==total, go to FINISH; otherwise clear all four flags and issue the next sector.
- Error:
  - Any sd_rsp_valid&sd_rsp_err or dma_done_valid&dma_done_err in XFER moves to ERROR.
  - Progress is not incremented for the failing sector.
  - ERROR sets status error=1 and irq_pending=1, drops both valids, then goes to IDLE the next cycle.
  - Completions arriving after the error, or while in IDLE, are ignored.
- FINISH: set done=1 and irq_pending=1, then go to IDLE the next cycle.
- busy = (state!=IDLE).
- Interrupt:
  - irq = irq_pending & int_en, registered.
  - interrupt_clear clears irq_pending in any state.
  - If set and clear occur in the same cycle, set wins.
- Soft reset:
  - reg_reset in any state, including mid-XFER with a handshake pending, returns to IDLE next cycle.
  - Clears valids, flags, idx, progress, done, error and irq_pending; no interrupt is raised.
  - reg_reset has priority over start in the same cycle.
- Handshake rule: a valid, once asserted, is never withdrawn before ready, except on soft reset or error.
- Latency: start pulse to first sd_cmd_valid/dma_req_valid = 2 cycles (XFER entry plus registered output).

Decomposition:
- Add to the shared sd_controller_pkg:
  - enum seq_state_t {IDLE, XFER, FINISH, ERROR};
  - constants STATUS_BUSY_BIT=0, STATUS_ERR_BIT=1, STATUS_IRQ_BIT=2, STATUS_DONE_BIT=3;
  - CTRL_START_BIT=0, CTRL_IRQEN_BIT=1.
- The register file also uses these constants.
- No sub-module is natural; the address/sector generation is two adders inside the block.

Test Plan:
- Transfer:
  - Stimulus: dstaddr=0x8000_0000, startsector=100, sectornum=4, int_en=1, start; SD/DMA ready and complete with 3-cycle delay.
  - Required: commands for sectors 100..103 at addresses 0x8000_0000, 0x8000_0200, 0x8000_0400, 0x8000_0600; progress steps 1..4; status=0xC then irq=1; interrupt_clear -> status=0x8, irq=0.
- Ordering:
  - Stimulus: dma_done_valid before sd_rsp_valid, same-cycle completions, and sd_cmd_ready held low 10 cycles.
  - Required: sd_cmd_valid and sd_cmd_sector stable all 10 cycles; exactly one advance per sector.
- Error:
  - Stimulus: sd_rsp_err on sector 2 of 6.
  - Required: progress=2, status=0x6, no further commands, and a later start clears error.
- Zero-length and interrupt:
  - sectornum=0 with int_en=0 -> no commands; status done=1, irq_pending=1; irq stays 0.
  - Start while busy -> ignored.
- Reset:
  - reg_reset mid-XFER with dma_req_valid pending -> valids 0 next cycle, status=0, progress=0.
  - aresetn asserted mid-transfer -> all outputs 0 immediately (asynchronous).
- Wrap-around:
  - dstaddr=0xFFFF_FE00, startsector=0xFFFF_FFFF, sectornum=2.
  - Required: second request uses address 0x0000_0000 and sector 0x0000_0000.
